// File: rtl/nx1_vfetch.sv
// nx1_vfetch: per-line VRAM prefetcher for the X1 video path.
// Burst-reads one display line of packed ABRG words into the back half of a
// double-buffered line store while the pixel serializer reads the front half.
//
// Handshakes with the memory controller:
//   command: mem_cmd_en is a one-cycle push. It is only raised when the
//            previous cycle saw mem_cmd_full low, and only one burst is ever
//            in flight.
//   read:    mem_rd_en pops a word in any cycle where we want data and
//            mem_rd_empty is low. mem_rd_data is taken in that same cycle.
module nx1_vfetch #(
    parameter logic [31:0] def_VBASE  = 32'h00180000,
    parameter int          def_BL     = 16,
    parameter int          def_LWORDS = 80
) (
    input  logic        mem_clk,
    input  logic        mem_rst_n,
    input  logic        mem_init_done,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_empty,
    input  logic        mem_cmd_full,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_empty,
    input  logic        v_line_start,
    input  logic [13:0] v_line_addr,
    input  logic        v_vbank,
    input  logic [6:0]  v_rd_addr,
    output logic [31:0] v_rd_data,
    output logic        v_busy,
    output logic        v_underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [7:0] BL_W     = 8'(def_BL);
    localparam logic [7:0] LWORDS_W = 8'(def_LWORDS);

    logic [1:0]  state;
    logic        rsel;
    logic [13:0] waddr;
    logic        vbank;
    logic [7:0]  remaining;
    logic [6:0]  wptr;
    logic [6:0]  beat;
    logic [13:0] pend_addr;
    logic        pend_vbank;

    logic [31:0] line_buf [0:255];

    logic        line_go;
    logic        pop;
    logic        last_beat;
    logic        line_done;
    logic [14:0] to_wrap;
    logic [7:0]  burst_n;
    logic [29:0] byte_addr;
    logic        do_start;
    logic        set_ur;
    logic [13:0] st_addr;
    logic        st_vbank;
    logic        unused_cmd_empty;

    // The command FIFO empty flag is reserved and not consumed.
    assign unused_cmd_empty = mem_cmd_empty;
    assign mem_cmd_instr    = 3'b001;
    assign mem_rd_en        = pop;

    // Burst sizing, address formation and the line-start decision for this cycle.
    always_comb begin
        line_go   = v_line_start & mem_init_done;
        pop       = ((state == ST_DATA) || (state == ST_DRAIN)) && !mem_rd_empty;
        last_beat = pop && (beat == 7'd1);
        line_done = (remaining == 8'd1);
        to_wrap   = 15'd16384 - {1'b0, waddr};
        burst_n   = BL_W;
        if (remaining < burst_n) burst_n = remaining;
        if (to_wrap < {7'd0, burst_n}) burst_n = to_wrap[7:0];
        byte_addr = def_VBASE[29:0] + {13'd0, vbank, waddr, 2'b00};

        do_start = 1'b0;
        set_ur   = 1'b0;
        st_addr  = v_line_addr;
        st_vbank = v_vbank;
        case (state)
            ST_IDLE: do_start = line_go;
            ST_CMD: begin
                do_start = line_go;
                set_ur   = line_go;
            end
            ST_DATA: begin
                if (line_go) begin
                    // A pulse on the closing beat of a burst needs no drain.
                    do_start = last_beat;
                    set_ur   = !(last_beat && line_done);
                end
            end
            default: begin
                set_ur   = line_go;
                do_start = last_beat;
                if (!line_go) begin
                    st_addr  = pend_addr;
                    st_vbank = pend_vbank;
                end
            end
        endcase
    end

    // Fetch sequencer: line start, command issue, beat counting and drain.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state             <= ST_IDLE;
            rsel              <= 1'b0;
            waddr             <= 14'd0;
            vbank             <= 1'b0;
            remaining         <= 8'd0;
            wptr              <= 7'd0;
            beat              <= 7'd0;
            pend_addr         <= 14'd0;
            pend_vbank        <= 1'b0;
            mem_cmd_en        <= 1'b0;
            mem_cmd_bl        <= 6'd0;
            mem_cmd_byte_addr <= 30'd0;
            v_busy            <= 1'b0;
            v_underrun        <= 1'b0;
        end else begin
            mem_cmd_en <= 1'b0;
            if (set_ur) v_underrun <= 1'b1;
            if (do_start) begin
                rsel      <= ~rsel;
                waddr     <= st_addr;
                vbank     <= st_vbank;
                remaining <= LWORDS_W;
                wptr      <= 7'd0;
                v_busy    <= 1'b1;
                state     <= ST_CMD;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_CMD: begin
                        if (!mem_cmd_full) begin
                            mem_cmd_en        <= 1'b1;
                            mem_cmd_bl        <= 6'(burst_n - 8'd1);
                            mem_cmd_byte_addr <= byte_addr;
                            beat              <= 7'(burst_n);
                            state             <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (pop) begin
                            wptr      <= wptr + 7'd1;
                            waddr     <= waddr + 14'd1;
                            remaining <= remaining - 8'd1;
                            beat      <= beat - 7'd1;
                            if (last_beat) begin
                                if (line_done) begin
                                    state  <= ST_IDLE;
                                    v_busy <= 1'b0;
                                end else begin
                                    state <= ST_CMD;
                                end
                            end
                        end
                        if (line_go) begin
                            pend_addr  <= v_line_addr;
                            pend_vbank <= v_vbank;
                            state      <= ST_DRAIN;
                        end
                    end
                    default: begin
                        if (pop) beat <= beat - 7'd1;
                        if (line_go) begin
                            pend_addr  <= v_line_addr;
                            pend_vbank <= v_vbank;
                        end
                    end
                endcase
            end
        end
    end

    // Writer side: accepted beats land in the back bank; drained beats are dropped.
    always_ff @(posedge mem_clk) begin
        if ((state == ST_DATA) && pop) line_buf[{~rsel, wptr}] <= mem_rd_data;
    end

    // Display side: registered read of the front bank.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) v_rd_data <= 32'd0;
        else            v_rd_data <= line_buf[{rsel, v_rd_addr}];
    end

endmodule

// File: tb/tb_nx1_vfetch.sv
// Bench for nx1_vfetch: a memory-controller stand-in, a line-level model of
// the fetcher and a per-cycle compare against it, plus literal checks.
`timescale 1ns/1ps
module tb_nx1_vfetch;

    localparam int LW    = 80;
    localparam int BL    = 16;
    localparam int VBASE = 32'h00180000;

    logic        mem_clk = 1'b0;
    logic        mem_rst_n = 1'b0;
    logic        mem_init_done = 1'b0;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_empty = 1'b0;
    logic        mem_cmd_full = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_rd_empty = 1'b1;
    logic        v_line_start = 1'b0;
    logic [13:0] v_line_addr = 14'd0;
    logic        v_vbank = 1'b0;
    logic [6:0]  v_rd_addr = 7'd0;
    logic [31:0] v_rd_data;
    logic        v_busy;
    logic        v_underrun;

    nx1_vfetch dut (
        .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .mem_init_done(mem_init_done),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_empty(mem_cmd_empty),
        .mem_cmd_full(mem_cmd_full), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_rd_empty(mem_rd_empty), .v_line_start(v_line_start), .v_line_addr(v_line_addr),
        .v_vbank(v_vbank), .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data),
        .v_busy(v_busy), .v_underrun(v_underrun)
    );

    // Clock block.
    always #5 mem_clk = ~mem_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench controls for the memory stand-in.
    bit       force_full = 0, rand_full = 0, stall_rd = 0, rand_empty = 0;
    bit       rd_pin_en = 0, data_seq = 0;
    logic [6:0] rd_pin = 7'd0;

    // Model state.
    bit          m_rsel, m_busy, m_ur, draining, prev_full;
    int          burst_left, words_done, issue_pos;
    logic [13:0] pend_addr;
    bit          pend_vb;
    logic [31:0] m_buf [2][128];
    bit          m_valid [2][128];
    logic [31:0] rdq [$];
    logic [29:0] exp_addr_q [$];
    logic [5:0]  exp_bl_q [$];
    logic [29:0] cmd_log_addr [$];
    logic [5:0]  cmd_log_bl [$];
    logic [31:0] exp_rd;
    bit          exp_rd_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected command list for one line, from burst-size rules in plain arithmetic.
    function automatic void gen_line(input int a, input int vb);
        int rem = LW;
        int w = a;
        int n;
        exp_addr_q.delete();
        exp_bl_q.delete();
        while (rem > 0) begin
            n = BL;
            if (rem < n) n = rem;
            if (16384 - w < n) n = 16384 - w;
            exp_addr_q.push_back(30'(VBASE + vb * 65536 + w * 4));
            exp_bl_q.push_back(6'(n - 1));
            w = (w + n) % 16384;
            rem -= n;
        end
    endfunction

    function automatic void start_line(input logic [13:0] a, input bit vb);
        m_rsel     = ~m_rsel;
        m_busy     = 1;
        words_done = 0;
        issue_pos  = 0;
        draining   = 0;
        gen_line(int'(a), int'(vb));
    endfunction

    // Memory stand-in driver: presents FIFO flags/data and display address.
    always @(posedge mem_clk) begin
        #1;
        mem_rd_empty = (rdq.size() == 0) || stall_rd || (rand_empty && $urandom_range(0, 3) == 0);
        mem_rd_data  = (rdq.size() != 0) ? rdq[0] : $urandom;
        mem_cmd_full = force_full || (rand_full && $urandom_range(0, 5) == 0);
        v_rd_addr    = rd_pin_en ? rd_pin : 7'($urandom_range(0, 127));
    end

    // Scoreboard: compare registered outputs, then apply this cycle's events to the model.
    logic [31:0] w_pop;
    bit          pop_m;
    int          n_words;
    always @(negedge mem_clk) begin
        if (!mem_rst_n) begin
            m_rsel = 0; m_busy = 0; m_ur = 0; draining = 0; prev_full = 0;
            burst_left = 0; words_done = 0; issue_pos = 0;
            rdq.delete(); exp_addr_q.delete(); exp_bl_q.delete();
            exp_rd = 32'd0; exp_rd_valid = 1;
        end else begin
            check("v_busy", {31'd0, v_busy}, {31'd0, m_busy});
            check("v_underrun", {31'd0, v_underrun}, {31'd0, m_ur});
            if (exp_rd_valid) check("v_rd_data", v_rd_data, exp_rd);
            if (prev_full) check("cmd_en_while_full", {31'd0, mem_cmd_en}, 32'd0);
            if (mem_cmd_en) begin
                cmd_log_addr.push_back(mem_cmd_byte_addr);
                cmd_log_bl.push_back(mem_cmd_bl);
                check("cmd_instr", {29'd0, mem_cmd_instr}, 32'd1);
                check("cmd_expected", {31'd0, (exp_addr_q.size() != 0) && (burst_left == 0)}, 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("cmd_addr", {2'd0, mem_cmd_byte_addr}, {2'd0, exp_addr_q[0]});
                    check("cmd_bl", {26'd0, mem_cmd_bl}, {26'd0, exp_bl_q[0]});
                    n_words = int'(exp_bl_q[0]) + 1;
                    void'(exp_addr_q.pop_front());
                    void'(exp_bl_q.pop_front());
                    burst_left = n_words;
                    for (int k = 0; k < n_words; k++)
                        rdq.push_back(data_seq ? 32'(issue_pos + k) : $urandom);
                    issue_pos += n_words;
                end
            end
            pop_m = (burst_left > 0) && !mem_rd_empty;
            check("rd_en", {31'd0, mem_rd_en}, {31'd0, pop_m});
            exp_rd       = m_buf[m_rsel][v_rd_addr];
            exp_rd_valid = m_valid[m_rsel][v_rd_addr];
            if (pop_m && rdq.size() != 0) begin
                w_pop = rdq.pop_front();
                burst_left--;
                if (!draining) begin
                    m_buf[!m_rsel][words_done]   = w_pop;
                    m_valid[!m_rsel][words_done] = 1;
                    words_done++;
                    if (words_done == LW) m_busy = 0;
                end
            end
            if (v_line_start && mem_init_done) begin
                if (!m_busy) begin
                    start_line(v_line_addr, v_vbank);
                end else if (draining) begin
                    m_ur = 1; pend_addr = v_line_addr; pend_vb = v_vbank;
                end else if (burst_left == 0) begin
                    m_ur = 1;
                    start_line(v_line_addr, v_vbank);
                end else begin
                    m_ur = 1; draining = 1; pend_addr = v_line_addr; pend_vb = v_vbank;
                end
            end
            if (draining && burst_left == 0) start_line(pend_addr, pend_vb);
            prev_full = mem_cmd_full;
        end
    end

    // Driver tasks.
    task automatic pulse_line(input logic [13:0] a, input bit vb);
        @(posedge mem_clk); #1;
        v_line_addr  = a;
        v_vbank      = vb;
        v_line_start = 1'b1;
        @(posedge mem_clk); #1;
        v_line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (m_busy && cyc < 3000) begin
            @(negedge mem_clk);
            cyc++;
        end
        check("line_timeout", {31'd0, m_busy}, 32'd0);
        repeat (2) @(negedge mem_clk);
    endtask

    task automatic check_cmd(input int idx, input logic [29:0] a, input logic [5:0] bl);
        if (cmd_log_addr.size() > idx) begin
            check($sformatf("cmd%0d_addr", idx), {2'd0, cmd_log_addr[idx]}, {2'd0, a});
            check($sformatf("cmd%0d_bl", idx), {26'd0, cmd_log_bl[idx]}, {26'd0, bl});
        end else begin
            check($sformatf("cmd%0d_present", idx), cmd_log_addr.size(), idx + 1);
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 128; i++) m_valid[b][i] = 0;

        // Reset values.
        repeat (3) @(negedge mem_clk);
        check("rst_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
        check("rst_cmd_bl", {26'd0, mem_cmd_bl}, 32'd0);
        check("rst_cmd_addr", {2'd0, mem_cmd_byte_addr}, 32'd0);
        check("rst_rd_data", v_rd_data, 32'd0);
        check("rst_busy", {31'd0, v_busy}, 32'd0);
        check("rst_underrun", {31'd0, v_underrun}, 32'd0);
        @(posedge mem_clk); #1 mem_rst_n = 1'b1;

        // Init gating: pulse ignored while the controller is not calibrated.
        pulse_line(14'h0100, 1'b0);
        repeat (10) @(negedge mem_clk);
        check("gate_no_cmd", cmd_log_addr.size(), 0);
        check("gate_busy", {31'd0, v_busy}, 32'd0);
        check("gate_underrun", {31'd0, v_underrun}, 32'd0);
        mem_init_done = 1'b1;

        // Basic line with word k = k.
        data_seq = 1;
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h0000, 1'b0);
        wait_idle();
        check("basic_ncmd", cmd_log_addr.size(), 5);
        check_cmd(0, 30'h180000, 6'd15);
        check_cmd(1, 30'h180040, 6'd15);
        check_cmd(2, 30'h180080, 6'd15);
        check_cmd(3, 30'h1800C0, 6'd15);
        check_cmd(4, 30'h180100, 6'd15);
        rd_pin = 7'd37; rd_pin_en = 1;
        pulse_line(14'h2000, 1'b0);
        repeat (2) @(negedge mem_clk);
        check("basic_word37", v_rd_data, 32'd37);
        rd_pin_en = 0;
        wait_idle();

        // Bank select.
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h0000, 1'b1);
        wait_idle();
        check_cmd(0, 30'h190000, 6'd15);
        check_cmd(4, 30'h190100, 6'd15);

        // Plane wrap, and a partial first burst on plane 1.
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h3FF8, 1'b0);
        wait_idle();
        check_cmd(0, 30'h18FFE0, 6'd7);
        check_cmd(1, 30'h180000, 6'd15);
        check_cmd(5, 30'h180100, 6'd7);
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h3FFC, 1'b1);
        wait_idle();
        check_cmd(0, 30'h19FFF0, 6'd3);
        check_cmd(1, 30'h190000, 6'd15);
        check_cmd(5, 30'h190100, 6'd11);

        // Command and read backpressure.
        @(negedge mem_clk);
        force_full = 1;
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h0040, 1'b0);
        repeat (10) @(negedge mem_clk);
        check("bp_no_cmd", cmd_log_addr.size(), 0);
        force_full = 0;
        repeat (5) @(negedge mem_clk);
        check("bp_one_cmd", cmd_log_addr.size(), 1);
        stall_rd = 1;
        repeat (10) @(negedge mem_clk);
        check("bp_no_second_cmd", cmd_log_addr.size(), 1);
        stall_rd = 0;
        wait_idle();

        // Randomized complete lines.
        data_seq = 0; rand_empty = 1; rand_full = 1;
        for (int i = 0; i < 8; i++) begin
            pulse_line(14'($urandom), 1'($urandom));
            wait_idle();
        end

        // Overrun mid-burst.
        rand_empty = 0; rand_full = 0;
        pulse_line(14'h0000, 1'b0);
        for (int k = 0; k < 500 && words_done < 6; k++) @(negedge mem_clk);
        cmd_log_addr.delete(); cmd_log_bl.delete();
        pulse_line(14'h1000, 1'b1);
        @(negedge mem_clk);
        check("ovr_underrun", {31'd0, v_underrun}, 32'd1);
        wait_idle();
        check_cmd(0, 30'h194000, 6'd15);

        // Randomized overruns at arbitrary points.
        rand_empty = 1; rand_full = 1;
        for (int i = 0; i < 10; i++) begin
            pulse_line(14'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 60)) @(posedge mem_clk);
        end
        wait_idle();

        // Reset mid-burst.
        pulse_line(14'h0123, 1'b0);
        repeat (20) @(posedge mem_clk);
        #2 mem_rst_n = 1'b0;
        @(negedge mem_clk);
        check("midrst_busy", {31'd0, v_busy}, 32'd0);
        check("midrst_underrun", {31'd0, v_underrun}, 32'd0);
        check("midrst_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
        @(posedge mem_clk); #2 mem_rst_n = 1'b1;
        pulse_line(14'h0777, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #900000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nx1_vfetch.md
Name: nx1_vfetch

Overview:
- Video line prefetcher for the X1 VRAM image at def_VBASE (ABRG planes packed one byte lane each: A=D[7:0], B=D[15:8], R=D[23:16], G=D[31:24]).
- It is the read-side consumer of the VRAM that the Z80 bank/VRAM port writes.
- Per display line it issues burst read commands on its own memory-controller port and fills one half of a double-buffered line store.
- The CRTC/pixel serializer reads the other half at random.

Parameters:
def_VBASE, 32'h00180000, byte base of VRAM ABRG 0; ABRG 1 is at def_VBASE+32'h10000.
def_BL, 16, maximum burst length in 32-bit words; legal range 1..64.
def_LWORDS, 80, words fetched per line; legal range 1..128.

Ports:
mem_clk  in  1  clock; all logic on the rising edge.
mem_rst_n  in  1  asynchronous active-low reset.
mem_init_done  in  1  memory controller calibrated.
mem_cmd_en  out  1  command push strobe, one cycle per burst.
mem_cmd_instr  out  3  always 3'b001 (read).
mem_cmd_bl  out  6  burst length minus 1.
mem_cmd_byte_addr  out  30  burst start byte address; bits [1:0] always 0.
mem_cmd_empty  in  1  command FIFO empty (unused; reserved).
mem_cmd_full  in  1  command FIFO full.
mem_rd_en  out  1  read FIFO pop.
mem_rd_data  in  32  read FIFO data.
mem_rd_empty  in  1  read FIFO empty.
v_line_start  in  1  one-cycle pulse: swap buffers and fetch the next line.
v_line_addr  in  14  start word address within the plane (latched on v_line_start).
v_vbank  in  1  0 = ABRG 0, 1 = ABRG 1 (latched on v_line_start).
v_rd_addr  in  7  display read word index.
v_rd_data  out  32  display read data (ABRG byte lanes).
v_busy  out  1  fetch in progress.
v_underrun  out  1  sticky; set when v_line_start arrives while busy.

Behaviour:
- Reset values: mem_cmd_en 0, mem_cmd_bl 0, mem_cmd_byte_addr 0, v_rd_data 0, v_busy 0, v_underrun 0, read-bank select 0, state IDLE.
- mem_rd_en = (state==DATA or DRAIN) & !mem_rd_empty.
- Storage: 2 banks x 128 x 32-bit words.
  - Writer fills bank ~rsel; reader reads bank rsel.
  - v_rd_data is registered from [rsel][v_rd_addr], 1-cycle latency.
- Address formation:
  - byte addr = def_VBASE[29:0] + {v_vbank, waddr[13:0], 2'b00}.
  - waddr wraps modulo 2^14 within the plane; it never carries into v_vbank.
- Burst length n = min(def_BL, remaining words, 16384 - waddr), so no burst crosses the plane wrap.
- FSM:
  - IDLE: v_line_start & mem_init_done → toggle rsel; latch addr/vbank; remaining = def_LWORDS; wptr = 0; v_busy = 1 → CMD. With mem_init_done = 0, v_line_start is ignored entirely (no swap, no flag).
  - CMD: when !mem_cmd_full, pulse mem_cmd_en for one cycle with bl = n-1 and the current byte addr; load beat counter = n → DATA. While mem_cmd_full is high, hold and keep mem_cmd_en = 0.
  - DATA: each pop writes mem_rd_data to [~rsel][wptr], then wptr+1, waddr+1 (wrap), remaining-1, beat-1.
    - Last beat with remaining > 0 → CMD.
    - Last beat with remaining = 0 → IDLE, v_busy = 0.
  - DRAIN: on v_line_start while in CMD (before en) or DATA, set v_underrun = 1.
    - If in CMD before en: restart immediately at IDLE semantics (swap, latch).
    - If in DATA: pop and discard the remaining beats of the current burst without writing the buffer, then perform the pending restart with the values latched at the pulse.
    - A v_line_start in DRAIN overwrites the pending values.
- Only one command is ever outstanding.
- v_line_start coincident with the final DATA beat: the beat completes normally, then the new line starts; v_underrun is not set.
- Reset mid-burst: immediate return to IDLE. Data still in the controller FIFO after reset is the controller's responsibility; the controller is reset by the same mem_rst_n.

Test Plan:
- Basic line: defaults, v_vbank=0, v_line_addr=0 → 5 commands at byte addrs 0x180000, 0x180040, 0x180080, 0x1800C0, 0x180100, each bl=15. Feed word k = k. After the next v_line_start, v_rd_addr=37 returns 37 one cycle later.
- Plane wrap: v_line_addr=14'h3FF8, def_LWORDS=24 → cmds (0x18FFE0, bl=7), (0x180000, bl=15); buffer words 0..23 in order.
- Bank and partial burst: v_vbank=1, addr 0, def_LWORDS=20 → cmds (0x190000, bl=15), (0x190040, bl=3).
- Backpressure: hold mem_cmd_full high for 10 cycles in CMD → no mem_cmd_en during the stall; exactly one en after release. Empty read FIFO stalls DATA with mem_rd_en = 0.
- Overrun: v_line_start after 6 of 16 beats → v_underrun=1; 10 beats popped and discarded; new first command at the new address; the old bank is not corrupted.
- Init gating: mem_init_done=0 plus a v_line_start pulse → no command, rsel unchanged, v_busy=0, v_underrun=0.
